z_stencil_test_pipe: RTL and testbench

Parametrised, fully pipelined per-sample depth and stencil test unit for MSAA fragments. It sits between the rasterizer/early-Z read path and the tile buffer controller. It supersedes the single-depth-test stage with three additions:
- eight depth compare functions;
- a stencil test with fail/zfail/zpass ops and read/write masks;
- an occlusion-query counter.

It sustains one fragment per cycle under valid/ready backpressure.

---
 rtl/z_stencil_test_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_z_stencil_test_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z_stencil_test_pipe.sv
// z_stencil_test_pipe
// Per-sample MSAA depth and stencil test, two register stages, valid/ready
// handshake on both sides, with a saturating occlusion-query counter.
//   S1: depth and stencil compares, plus the operands and controls S2 needs
//   S2: stencil op selection and write-mask merge, registered as the outputs
module z_stencil_test_pipe #(
    parameter int DEPTH_WIDTH   = 24,
    parameter int SAMPLE_COUNT  = 4,
    parameter int STENCIL_WIDTH = 8,
    parameter int QUERY_WIDTH   = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [SAMPLE_COUNT-1:0]                in_mask,
    input  logic [DEPTH_WIDTH*SAMPLE_COUNT-1:0]    in_depth,
    input  logic [DEPTH_WIDTH*SAMPLE_COUNT-1:0]    in_mem_depth,
    input  logic [STENCIL_WIDTH*SAMPLE_COUNT-1:0]  in_mem_stencil,
    input  logic [2:0]                             cmp_func,
    input  logic                                   depth_write_en,
    input  logic                                   stencil_en,
    input  logic [2:0]                             stencil_func,
    input  logic [STENCIL_WIDTH-1:0]               stencil_ref,
    input  logic [STENCIL_WIDTH-1:0]               stencil_read_mask,
    input  logic [STENCIL_WIDTH-1:0]               stencil_write_mask,
    input  logic [2:0]                             sop_fail,
    input  logic [2:0]                             sop_zfail,
    input  logic [2:0]                             sop_zpass,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [SAMPLE_COUNT-1:0]                out_pass_mask,
    output logic [SAMPLE_COUNT-1:0]                out_depth_we,
    output logic [DEPTH_WIDTH*SAMPLE_COUNT-1:0]    out_write_depth,
    output logic [SAMPLE_COUNT-1:0]                out_stencil_we,
    output logic [STENCIL_WIDTH*SAMPLE_COUNT-1:0]  out_write_stencil,
    input  logic                                   query_clear,
    output logic [QUERY_WIDTH-1:0]                 query_count
);

    localparam int DW = DEPTH_WIDTH;
    localparam int SC = SAMPLE_COUNT;
    localparam int SW = STENCIL_WIDTH;
    localparam int QW = QUERY_WIDTH;

    localparam logic [SW-1:0] ST_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] ST_ONES = {SW{1'b1}};
    localparam logic [SW-1:0] ST_ONE  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [QW-1:0] Q_ZERO  = {QW{1'b0}};
    localparam logic [QW-1:0] Q_ONES  = {QW{1'b1}};

    // Compare function shared by depth and stencil: src op dst, unsigned.
    function automatic logic cmp_eval(input logic [2:0] func,
                                      input logic       lt,
                                      input logic       eq);
        logic res;
        case (func)
            3'd0:    res = 1'b0;          // NEVER
            3'd1:    res = lt;            // LESS
            3'd2:    res = eq;            // EQUAL
            3'd3:    res = lt | eq;       // LEQUAL
            3'd4:    res = ~lt & ~eq;     // GREATER
            3'd5:    res = ~eq;           // NOTEQUAL
            3'd6:    res = ~lt;           // GEQUAL
            3'd7:    res = 1'b1;          // ALWAYS
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Pick the stencil op from the per-sample test outcome.
    function automatic logic [2:0] select_op(input logic       s_pass,
                                             input logic       d_pass,
                                             input logic [2:0] op_fail,
                                             input logic [2:0] op_zfail,
                                             input logic [2:0] op_zpass);
        logic [2:0] op;
        if (!s_pass) begin
            op = op_fail;
        end else if (!d_pass) begin
            op = op_zfail;
        end else begin
            op = op_zpass;
        end
        return op;
    endfunction

    // Apply a stencil op to the old value (before write masking).
    function automatic logic [SW-1:0] stencil_apply(input logic [2:0]    op,
                                                    input logic [SW-1:0] old_val,
                                                    input logic [SW-1:0] ref_val);
        logic [SW-1:0] res;
        case (op)
            3'd0:    res = old_val;                                        // KEEP
            3'd1:    res = ST_ZERO;                                        // ZERO
            3'd2:    res = ref_val;                                        // REPLACE
            3'd3:    res = (old_val == ST_ONES) ? ST_ONES : old_val + ST_ONE; // INCR_SAT
            3'd4:    res = (old_val == ST_ZERO) ? ST_ZERO : old_val - ST_ONE; // DECR_SAT
            3'd5:    res = ~old_val;                                       // INVERT
            3'd6:    res = old_val + ST_ONE;                               // INCR_WRAP
            3'd7:    res = old_val - ST_ONE;                               // DECR_WRAP
            default: res = old_val;
        endcase
        return res;
    endfunction

    // Number of set bits in a pass mask, one bit wider than the counter.
    function automatic logic [QW:0] popcount(input logic [SC-1:0] bits);
        logic [QW:0] cnt;
        cnt = {(QW+1){1'b0}};
        for (int i = 0; i < SC; i++) begin
            if (bits[i]) begin
                cnt = cnt + {{QW{1'b0}}, 1'b1};
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_r;
    logic adv1_s;
    logic adv2_s;

    assign adv2_s   = !out_valid || out_ready;
    assign adv1_s   = !s1_valid_r || adv2_s;
    assign in_ready = adv1_s;

    // ------------------------------------------------------------------
    // Input-side compares
    // ------------------------------------------------------------------
    logic [SC-1:0] depth_pass_s;
    logic [SC-1:0] stencil_pass_s;
    logic [SW-1:0] ref_masked_s;

    assign ref_masked_s = stencil_ref & stencil_read_mask;

    // Per-sample depth and stencil compares on the incoming fragment.
    always_comb begin
        depth_pass_s   = {SC{1'b0}};
        stencil_pass_s = {SC{1'b0}};
        for (int i = 0; i < SC; i++) begin
            depth_pass_s[i] = cmp_eval(cmp_func,
                                       in_depth[i*DW +: DW] <  in_mem_depth[i*DW +: DW],
                                       in_depth[i*DW +: DW] == in_mem_depth[i*DW +: DW]);
            if (stencil_en) begin
                stencil_pass_s[i] = cmp_eval(stencil_func,
                    ref_masked_s <  (in_mem_stencil[i*SW +: SW] & stencil_read_mask),
                    ref_masked_s == (in_mem_stencil[i*SW +: SW] & stencil_read_mask));
            end else begin
                stencil_pass_s[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [SC-1:0]    s1_mask_r;
    logic [SC-1:0]    s1_depth_pass_r;
    logic [SC-1:0]    s1_stencil_pass_r;
    logic [DW*SC-1:0] s1_depth_r;
    logic [SW*SC-1:0] s1_mem_stencil_r;
    logic             s1_depth_write_en_r;
    logic             s1_stencil_en_r;
    logic [SW-1:0]    s1_ref_r;
    logic [SW-1:0]    s1_wmask_r;
    logic [2:0]       s1_sop_fail_r;
    logic [2:0]       s1_sop_zfail_r;
    logic [2:0]       s1_sop_zpass_r;

    // Stage 1 valid: refills whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 1 payload: compare results and the controls sampled with the fragment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_mask_r           <= {SC{1'b0}};
            s1_depth_pass_r     <= {SC{1'b0}};
            s1_stencil_pass_r   <= {SC{1'b0}};
            s1_depth_r          <= {(DW*SC){1'b0}};
            s1_mem_stencil_r    <= {(SW*SC){1'b0}};
            s1_depth_write_en_r <= 1'b0;
            s1_stencil_en_r     <= 1'b0;
            s1_ref_r            <= ST_ZERO;
            s1_wmask_r          <= ST_ZERO;
            s1_sop_fail_r       <= 3'd0;
            s1_sop_zfail_r      <= 3'd0;
            s1_sop_zpass_r      <= 3'd0;
        end else if (adv1_s && in_valid) begin
            s1_mask_r           <= in_mask;
            s1_depth_pass_r     <= depth_pass_s;
            s1_stencil_pass_r   <= stencil_pass_s;
            s1_depth_r          <= in_depth;
            s1_mem_stencil_r    <= in_mem_stencil;
            s1_depth_write_en_r <= depth_write_en;
            s1_stencil_en_r     <= stencil_en;
            s1_ref_r            <= stencil_ref;
            s1_wmask_r          <= stencil_write_mask;
            s1_sop_fail_r       <= sop_fail;
            s1_sop_zfail_r      <= sop_zfail;
            s1_sop_zpass_r      <= sop_zpass;
        end else begin
            s1_mask_r           <= s1_mask_r;
            s1_depth_pass_r     <= s1_depth_pass_r;
            s1_stencil_pass_r   <= s1_stencil_pass_r;
            s1_depth_r          <= s1_depth_r;
            s1_mem_stencil_r    <= s1_mem_stencil_r;
            s1_depth_write_en_r <= s1_depth_write_en_r;
            s1_stencil_en_r     <= s1_stencil_en_r;
            s1_ref_r            <= s1_ref_r;
            s1_wmask_r          <= s1_wmask_r;
            s1_sop_fail_r       <= s1_sop_fail_r;
            s1_sop_zfail_r      <= s1_sop_zfail_r;
            s1_sop_zpass_r      <= s1_sop_zpass_r;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 next-state logic
    // ------------------------------------------------------------------
    logic [SC-1:0]    pass_s;
    logic [SC-1:0]    depth_we_s;
    logic [SC-1:0]    stencil_we_s;
    logic [SW*SC-1:0] write_stencil_s;
    logic             wmask_any_s;

    assign wmask_any_s = (s1_wmask_r != ST_ZERO);

    // Per-sample op, write-mask merge and enables for the stage 1 fragment.
    always_comb begin
        pass_s          = {SC{1'b0}};
        depth_we_s      = {SC{1'b0}};
        stencil_we_s    = {SC{1'b0}};
        write_stencil_s = {(SW*SC){1'b0}};
        for (int i = 0; i < SC; i++) begin
            pass_s[i]       = s1_mask_r[i] & s1_stencil_pass_r[i] & s1_depth_pass_r[i];
            depth_we_s[i]   = pass_s[i] & s1_depth_write_en_r;
            stencil_we_s[i] = s1_mask_r[i] & s1_stencil_en_r & wmask_any_s;
            write_stencil_s[i*SW +: SW] =
                (s1_mem_stencil_r[i*SW +: SW] & ~s1_wmask_r) |
                (stencil_apply(select_op(s1_stencil_pass_r[i], s1_depth_pass_r[i],
                                         s1_sop_fail_r, s1_sop_zfail_r, s1_sop_zpass_r),
                               s1_mem_stencil_r[i*SW +: SW], s1_ref_r) & s1_wmask_r);
        end
    end

    // Stage 2 valid: holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (adv2_s) begin
            out_valid <= s1_valid_r;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Stage 2 output registers, frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pass_mask     <= {SC{1'b0}};
            out_depth_we      <= {SC{1'b0}};
            out_write_depth   <= {(DW*SC){1'b0}};
            out_stencil_we    <= {SC{1'b0}};
            out_write_stencil <= {(SW*SC){1'b0}};
        end else if (adv2_s && s1_valid_r) begin
            out_pass_mask     <= pass_s;
            out_depth_we      <= depth_we_s;
            out_write_depth   <= s1_depth_r;
            out_stencil_we    <= stencil_we_s;
            out_write_stencil <= write_stencil_s;
        end else begin
            out_pass_mask     <= out_pass_mask;
            out_depth_we      <= out_depth_we;
            out_write_depth   <= out_write_depth;
            out_stencil_we    <= out_stencil_we;
            out_write_stencil <= out_write_stencil;
        end
    end

    // ------------------------------------------------------------------
    // Occlusion-query counter
    // ------------------------------------------------------------------
    logic          transfer_s;
    logic [QW:0]   query_sum_s;
    logic [QW-1:0] query_next_s;

    assign transfer_s = out_valid && out_ready;

    // Saturating add of the transferred pass count; a clear drops the old total.
    always_comb begin
        query_sum_s  = {(QW+1){1'b0}};
        query_next_s = query_count;
        if (transfer_s) begin
            if (query_clear) begin
                query_sum_s = popcount(out_pass_mask);
            end else begin
                query_sum_s = {1'b0, query_count} + popcount(out_pass_mask);
            end
            query_next_s = query_sum_s[QW] ? Q_ONES : query_sum_s[QW-1:0];
        end else if (query_clear) begin
            query_next_s = Q_ZERO;
        end else begin
            query_next_s = query_count;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            query_count <= Q_ZERO;
        end else begin
            query_count <= query_next_s;
        end
    end

endmodule

// File: tb/tb_z_stencil_test_pipe.sv
// Directed testbench for z_stencil_test_pipe (QUERY_WIDTH = 4 to reach saturation).
module tb_z_stencil_test_pipe;

    localparam int DW = 24;
    localparam int SC = 4;
    localparam int SW = 8;
    localparam int QW = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [SC-1:0]     in_mask;
    logic [DW*SC-1:0]  in_depth;
    logic [DW*SC-1:0]  in_mem_depth;
    logic [SW*SC-1:0]  in_mem_stencil;
    logic [2:0]        cmp_func;
    logic              depth_write_en;
    logic              stencil_en;
    logic [2:0]        stencil_func;
    logic [SW-1:0]     stencil_ref;
    logic [SW-1:0]     stencil_read_mask;
    logic [SW-1:0]     stencil_write_mask;
    logic [2:0]        sop_fail;
    logic [2:0]        sop_zfail;
    logic [2:0]        sop_zpass;
    logic              out_valid;
    logic              out_ready;
    logic [SC-1:0]     out_pass_mask;
    logic [SC-1:0]     out_depth_we;
    logic [DW*SC-1:0]  out_write_depth;
    logic [SC-1:0]     out_stencil_we;
    logic [SW*SC-1:0]  out_write_stencil;
    logic              query_clear;
    logic [QW-1:0]     query_count;

    int checks = 0;
    int errors = 0;

    z_stencil_test_pipe #(
        .DEPTH_WIDTH(DW), .SAMPLE_COUNT(SC), .STENCIL_WIDTH(SW), .QUERY_WIDTH(QW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
        .in_depth(in_depth), .in_mem_depth(in_mem_depth), .in_mem_stencil(in_mem_stencil),
        .cmp_func(cmp_func), .depth_write_en(depth_write_en),
        .stencil_en(stencil_en), .stencil_func(stencil_func), .stencil_ref(stencil_ref),
        .stencil_read_mask(stencil_read_mask), .stencil_write_mask(stencil_write_mask),
        .sop_fail(sop_fail), .sop_zfail(sop_zfail), .sop_zpass(sop_zpass),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pass_mask(out_pass_mask), .out_depth_we(out_depth_we),
        .out_write_depth(out_write_depth), .out_stencil_we(out_stencil_we),
        .out_write_stencil(out_write_stencil),
        .query_clear(query_clear), .query_count(query_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one fragment for a single cycle (pipeline assumed ready).
    task automatic send();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic set_defaults();
        in_valid           = 1'b0;
        in_mask            = 4'hF;
        in_depth           = {4{24'h000100}};
        in_mem_depth       = {4{24'h000100}};
        in_mem_stencil     = {4{8'h00}};
        cmp_func           = 3'd7;
        depth_write_en     = 1'b0;
        stencil_en         = 1'b0;
        stencil_func       = 3'd7;
        stencil_ref        = 8'h00;
        stencil_read_mask  = 8'hFF;
        stencil_write_mask = 8'hFF;
        sop_fail           = 3'd0;
        sop_zfail          = 3'd0;
        sop_zpass          = 3'd0;
        out_ready          = 1'b1;
        query_clear        = 1'b0;
    endtask

    // Single stencil op with both tests forced to pass (zpass path).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] mem,
                          input logic [7:0] refv, input logic [7:0] wmask, input logic [7:0] exp);
        set_defaults();
        stencil_en         = 1'b1;
        sop_zpass          = op;
        in_mem_stencil     = {4{mem}};
        stencil_ref        = refv;
        stencil_write_mask = wmask;
        send();
        step();
        check({tag, "_val"}, out_write_stencil, {4{exp}});
        check({tag, "_we"}, out_stencil_we, 4'hF);
    endtask

    logic [3:0] exp_cmp [8] = '{4'b0000, 4'b0100, 4'b1010, 4'b1110,
                                4'b0001, 4'b0101, 4'b1011, 4'b1111};

    task automatic setup_t1();
        set_defaults();
        cmp_func       = 3'd1;
        depth_write_en = 1'b1;
        in_depth       = {4{24'h000100}};
        in_mem_depth   = {24'hFFFFFF, 24'h000200, 24'h000100, 24'h000080};
    endtask

    initial begin
        int acc;
        int n;
        logic rdy;

        set_defaults();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_query", query_count, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        // 1: depth LESS, latency 2
        setup_t1();
        send();
        check("t1_lat1", out_valid, 1'b0);
        step();
        check("t1_valid", out_valid, 1'b1);
        check("t1_pass", out_pass_mask, 4'b1100);
        check("t1_dwe", out_depth_we, 4'b1100);
        check("t1_wdepth", out_write_depth, {4{24'h000100}});
        check("t1_swe", out_stencil_we, 4'b0000);

        // depth compare functions: samples are src>dst, eq, src<dst, eq
        for (int f = 0; f < 8; f++) begin
            set_defaults();
            cmp_func     = 3'(f);
            in_mem_depth = {24'h000100, 24'h000200, 24'h000100, 24'h000080};
            send();
            step();
            check($sformatf("cmp_func%0d", f), out_pass_mask, exp_cmp[f]);
        end

        // 2: stencil EQUAL with op selection
        set_defaults();
        stencil_en     = 1'b1;
        stencil_func   = 3'd2;
        stencil_ref    = 8'h05;
        in_mem_stencil = {8'h05, 8'h05, 8'h04, 8'h05};
        cmp_func       = 3'd1;
        depth_write_en = 1'b1;
        in_mem_depth   = {24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
        sop_fail       = 3'd1;
        sop_zfail      = 3'd4;
        sop_zpass      = 3'd6;
        send();
        step();
        check("t2_stencil", out_write_stencil, 32'h06040006);
        check("t2_swe", out_stencil_we, 4'b1111);
        check("t2_pass", out_pass_mask, 4'b1001);
        check("t2_dwe", out_depth_we, 4'b1001);

        // 3: saturation / wrap / masks
        run_op("incr_sat", 3'd3, 8'hFF, 8'h00, 8'hFF, 8'hFF);
        run_op("incr_wrap", 3'd6, 8'hFF, 8'h00, 8'hFF, 8'h00);
        run_op("decr_sat", 3'd4, 8'h00, 8'h00, 8'hFF, 8'h00);
        run_op("decr_wrap", 3'd7, 8'h00, 8'h00, 8'hFF, 8'hFF);
        run_op("invert_wm", 3'd5, 8'hA5, 8'h00, 8'h0F, 8'hAA);
        run_op("replace", 3'd2, 8'h11, 8'h3C, 8'hFF, 8'h3C);
        run_op("keep", 3'd0, 8'h77, 8'h3C, 8'hFF, 8'h77);

        // read mask applied to both sides; zero write mask disables stencil writes
        set_defaults();
        stencil_en         = 1'b1;
        stencil_func       = 3'd2;
        stencil_ref        = 8'h15;
        stencil_read_mask  = 8'h0F;
        stencil_write_mask = 8'h00;
        in_mem_stencil     = {8'hF5, 8'h05, 8'h26, 8'h25};
        send();
        step();
        check("rmask_pass", out_pass_mask, 4'b1101);
        check("wmask0_swe", out_stencil_we, 4'b0000);

        // uncovered samples get no enables
        set_defaults();
        in_mask        = 4'b0110;
        stencil_en     = 1'b1;
        depth_write_en = 1'b1;
        send();
        step();
        check("cov_pass", out_pass_mask, 4'b0110);
        check("cov_dwe", out_depth_we, 4'b0110);
        check("cov_swe", out_stencil_we, 4'b0110);
        step();

        // 4: backpressure
        set_defaults();
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_depth = {4{24'(24'h000A00 + 24'(acc))}};
            rdy = in_ready;
            step();
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 2);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_stable", out_write_depth[23:0], 24'h000A00);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) begin
                check($sformatf("bp_order%0d", n), out_write_depth[23:0], 24'(24'h000A00 + 24'(n)));
                n++;
            end
            step();
        end
        check("bp_count", n, 2);
        check("bp_drained", out_valid, 1'b0);

        // 5: occlusion counter
        set_defaults();
        query_clear = 1'b1;
        step();
        query_clear = 1'b0;
        check("q_clear", query_count, 4'd0);
        in_valid = 1'b1;
        in_mask = 4'hF;
        step();
        in_mask = 4'b0011;
        step();
        in_mask = 4'b0000;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("q_sum6", query_count, 4'd6);
        in_mask = 4'b0111;
        send();
        step();
        check("q_pre_clear_valid", out_valid, 1'b1);
        query_clear = 1'b1;
        step();
        query_clear = 1'b0;
        check("q_clear_xfer", query_count, 4'd3);
        in_mask = 4'hF;
        in_valid = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("q_sat", query_count, 4'd15);
        query_clear = 1'b1;
        step();
        query_clear = 1'b0;
        check("q_clear2", query_count, 4'd0);
        in_mask = 4'b0101;
        send();
        repeat (3) step();
        check("q_two", query_count, 4'd2);
        out_ready = 1'b0;
        in_mask = 4'hF;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        repeat (3) step();
        check("q_stall", query_count, 4'd2);
        check("stall_valid", out_valid, 1'b1);
        check("stall_full", in_ready, 1'b0);

        // 6: asynchronous reset with both stages full
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_query", query_count, 4'd0);
        check("arst_pass", out_pass_mask, 4'b0000);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post_rst_ready", in_ready, 1'b1);
        check("post_rst_empty", out_valid, 1'b0);
        setup_t1();
        send();
        check("post_rst_lat1", out_valid, 1'b0);
        step();
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_pass", out_pass_mask, 4'b1100);
        check("post_rst_dwe", out_depth_we, 4'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
